// File: rtl/conv_encoder_k3.sv
// Rate-1/2, constraint-length-3 convolutional encoder with optional per-frame
// zero-tail flushing. One information bit in, one 2-bit symbol out, one cycle
// later. After FRAME_LEN data bits, K-1 zero bits are encoded so the trellis
// returns to state 0 at every frame boundary.
module conv_encoder_k3 #(
  parameter int unsigned    K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101,
  parameter int unsigned    FRAME_LEN = 256,
  parameter bit             TAIL_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_encoder_i,
  input  logic        encoder_i,
  output logic        ready_o,
  output logic [1:0]  encoder_o,
  output logic        valid_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic [15:0] word_ct
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    TAIL = 2'b10
  } state_t;

  localparam int unsigned    M         = K - 1;
  localparam int unsigned    TCW       = (M > 1) ? $clog2(M) : 1;
  localparam logic [TCW-1:0] TAIL_LAST = TCW'(M - 1);
  localparam logic [15:0]    FL16      = 16'(FRAME_LEN);

  // Parity of the taps selected by generator polynomial g.
  function automatic logic parity_fn(input logic [K-1:0] v, input logic [K-1:0] g);
    return ^(v & g);
  endfunction

  // Code vector {b, sr[0], sr[1], ...}: MSB is the current bit, then newest to oldest history.
  function automatic logic [K-1:0] code_vec(input logic b, input logic [M-1:0] sr);
    logic [K-1:0] v;
    v = {K{1'b0}};
    v[K-1] = b;
    for (int i = 0; i < int'(M); i++) begin
      v[K-2-i] = sr[i];
    end
    return v;
  endfunction

  state_t           state_r, state_nx_s;
  logic [M-1:0]     sr_r, sr_nx_s, sr_shift_s;
  logic [TCW-1:0]   tail_ct_r, tail_ct_nx_s;
  logic [1:0]       enc_r, enc_nx_s, sym_s;
  logic             valid_r, valid_nx_s;
  logic             start_r, start_nx_s;
  logic             done_r, done_nx_s;
  logic [15:0]      word_ct_r, word_ct_nx_s;
  logic [15:0]      cnt_base_s, cnt_inc_s;
  logic             accept_s, bit_s, last_bit_s;
  logic [K-1:0]     code_s;

  assign ready_o       = (state_r != TAIL);
  assign accept_s      = enable_encoder_i & ready_o;
  assign bit_s         = (state_r == TAIL) ? 1'b0 : encoder_i;
  assign code_s        = code_vec(bit_s, sr_r);
  assign sym_s         = {parity_fn(code_s, G0), parity_fn(code_s, G1)};
  assign sr_shift_s    = M'({sr_r, bit_s});
  // A frame starting from IDLE counts from zero regardless of what word_ct still shows.
  assign cnt_base_s    = (state_r == IDLE) ? 16'd0 : word_ct_r;
  assign cnt_inc_s     = cnt_base_s + 16'd1;
  assign last_bit_s    = (cnt_inc_s == FL16);

  assign encoder_o     = enc_r;
  assign valid_o       = valid_r;
  assign frame_start_o = start_r;
  assign frame_done_o  = done_r;
  assign word_ct       = word_ct_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decision: data bits until FRAME_LEN, then tail (or straight back to IDLE).
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE, DATA: begin
        if (accept_s && last_bit_s) begin
          if (TAIL_EN) begin
            state_nx_s = TAIL;
          end else begin
            state_nx_s = IDLE;
          end
        end else if (accept_s) begin
          state_nx_s = DATA;
        end else begin
          state_nx_s = state_r;
        end
      end
      TAIL: begin
        if (tail_ct_r == TAIL_LAST) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = TAIL;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Next values of the symbol, flags, shift register, counters.
  always_comb begin
    enc_nx_s     = enc_r;
    valid_nx_s   = 1'b0;
    start_nx_s   = 1'b0;
    done_nx_s    = 1'b0;
    word_ct_nx_s = word_ct_r;
    sr_nx_s      = sr_r;
    tail_ct_nx_s = tail_ct_r;
    case (state_r)
      IDLE, DATA: begin
        if (accept_s) begin
          enc_nx_s     = sym_s;
          valid_nx_s   = 1'b1;
          start_nx_s   = (state_r == IDLE);
          done_nx_s    = last_bit_s & ~TAIL_EN;
          word_ct_nx_s = cnt_inc_s;
          sr_nx_s      = sr_shift_s;
          tail_ct_nx_s = {TCW{1'b0}};
        end else if (state_r == IDLE) begin
          word_ct_nx_s = 16'd0;
        end else begin
          word_ct_nx_s = word_ct_r;
        end
      end
      TAIL: begin
        enc_nx_s   = sym_s;
        valid_nx_s = 1'b1;
        if (tail_ct_r == TAIL_LAST) begin
          done_nx_s    = 1'b1;
          sr_nx_s      = {M{1'b0}};
          tail_ct_nx_s = {TCW{1'b0}};
        end else begin
          sr_nx_s      = sr_shift_s;
          tail_ct_nx_s = tail_ct_r + TCW'(1);
        end
      end
      default: begin
        enc_nx_s     = 2'b00;
        word_ct_nx_s = 16'd0;
        sr_nx_s      = {M{1'b0}};
        tail_ct_nx_s = {TCW{1'b0}};
      end
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_r      <= {M{1'b0}};
      tail_ct_r <= {TCW{1'b0}};
      enc_r     <= 2'b00;
      valid_r   <= 1'b0;
      start_r   <= 1'b0;
      done_r    <= 1'b0;
      word_ct_r <= 16'd0;
    end else begin
      sr_r      <= sr_nx_s;
      tail_ct_r <= tail_ct_nx_s;
      enc_r     <= enc_nx_s;
      valid_r   <= valid_nx_s;
      start_r   <= start_nx_s;
      done_r    <= done_nx_s;
      word_ct_r <= word_ct_nx_s;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Scoreboard bench for conv_encoder_k3 over four parameter sets. Each set has a
// driver that predicts symbols from a bit-history model and a monitor that
// pops predictions whenever valid_o is seen.
module tb_conv_encoder_k3;

  logic clk = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input int g, input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL cfg%0d %s: actual=%0d required=%0d", g, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int          FL_G     = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 256;
    localparam bit          TE_G     = (g == 2) ? 1'b0 : 1'b1;
    localparam int          NDB      = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 4 : 0;
    localparam logic [3:0]  DB       = (g == 0) ? 4'b1101 : (g == 1) ? 4'b0001 :
                                       (g == 2) ? 4'b0011 : 4'b0000;
    localparam int          NDS      = (g == 0) ? 6 : (g == 1) ? 3 : (g == 2) ? 4 : 0;
    localparam logic [11:0] DS       = (g == 0) ? 12'b11_01_01_00_10_11 :
                                       (g == 1) ? 12'b00_00_00_11_10_11 :
                                       (g == 2) ? 12'b00_00_11_01_01_11 : 12'd0;
    localparam int          STALL_AT = (g == 0) ? 2 : -1;
    localparam int          RST_AT   = (g == 0) ? 3 : (g == 3) ? 37 : 1;
    localparam int          NRAND    = 300;

    typedef struct packed {
      logic [1:0]  sym;
      logic        st;
      logic        dn;
      logic [15:0] wc;
    } exp_t;

    logic        rst_g, en_g, b_g, ready_g, valid_g, start_g, done_g;
    logic [1:0]  enc_g;
    logic [15:0] wct_g;

    exp_t        q[$];
    bit          hist[$];
    int          cnt = 0;
    int          busy = 0;
    bit          fin = 1'b0;
    bit          accepted = 1'b0;
    logic [1:0]  cap[8];
    int          ncap = 0;
    logic [1:0]  last_sym = 2'b00;
    bit          prev_done = 1'b0;
    exp_t        em;

    conv_encoder_k3 #(
      .K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(FL_G), .TAIL_EN(TE_G)
    ) dut (
      .clk(clk), .rst(rst_g), .enable_encoder_i(en_g), .encoder_i(b_g),
      .ready_o(ready_g), .encoder_o(enc_g), .valid_o(valid_g),
      .frame_start_o(start_g), .frame_done_o(done_g), .word_ct(wct_g)
    );

    // Model: symbol = {b ^ prev1 ^ prev2, b ^ prev2} over the running bit history.
    task automatic push_sym(input bit bv, input bit st, input bit dn, input int wc);
      bit   p1, p2;
      exp_t e;
      p1 = (hist.size() > 0) ? hist[hist.size()-1] : 1'b0;
      p2 = (hist.size() > 1) ? hist[hist.size()-2] : 1'b0;
      e.sym = {bv ^ p1 ^ p2, bv ^ p2};
      e.st  = st;
      e.dn  = dn;
      e.wc  = 16'(wc);
      q.push_back(e);
      hist.push_back(bv);
      if (hist.size() > 2) void'(hist.pop_front());
    endtask

    task automatic step(input bit want, input bit bv);
      @(negedge clk);
      en_g = want;
      b_g = bv;
      accepted = 1'b0;
      if (busy > 0) begin
        chk(g, "ready_in_tail", int'(ready_g), 0);
        push_sym(1'b0, 1'b0, busy == 1, FL_G);
        busy--;
        if (busy == 0) begin
          hist.delete();
          cnt = 0;
        end
      end else begin
        chk(g, "ready_in_data", int'(ready_g), 1);
        if (want) begin
          accepted = 1'b1;
          cnt++;
          push_sym(bv, cnt == 1, (cnt == FL_G) && !TE_G, cnt);
          if (cnt == FL_G) begin
            if (TE_G) busy = 2;
            else cnt = 0;
          end
        end
      end
    endtask

    task automatic send(input bit bv);
      int tries;
      tries = 0;
      do begin
        step(1'b1, bv);
        tries++;
      end while (!accepted && tries < 10);
      chk(g, "send_accepted", int'(accepted), 1);
    endtask

    task automatic check_reset_outputs(input string nm);
      chk(g, {nm, "_enc"}, int'(enc_g), 0);
      chk(g, {nm, "_valid"}, int'(valid_g), 0);
      chk(g, {nm, "_wct"}, int'(wct_g), 0);
      chk(g, {nm, "_start"}, int'(start_g), 0);
      chk(g, {nm, "_done"}, int'(done_g), 0);
      chk(g, {nm, "_ready"}, int'(ready_g), 1);
    endtask

    task automatic do_reset();
      @(negedge clk);
      en_g = 1'b0;
      #1 rst_g = 1'b0;
      #1 check_reset_outputs("midrst");
      q.delete();
      hist.delete();
      cnt = 0;
      busy = 0;
      @(negedge clk);
      @(negedge clk);
      rst_g = 1'b1;
    endtask

    // Driver: reset, directed patterns, random run with one mid-frame reset, drain.
    initial begin
      int acc;
      bit did, w;
      rst_g = 1'b0;
      en_g = 1'b1;
      b_g = 1'b0;
      repeat (3) begin
        @(negedge clk);
        b_g = 1'($urandom);
        check_reset_outputs("rst");
      end
      @(negedge clk);
      rst_g = 1'b1;
      en_g = 1'b0;
      for (int i = 0; i < NDB; i++) begin
        send(DB[i]);
        if (i + 1 == STALL_AT) begin
          repeat (5) step(1'b0, 1'($urandom));
        end
      end
      acc = 0;
      did = 1'b0;
      for (int c = 0; c < NRAND * 4 && acc < NRAND; c++) begin
        w = ($urandom_range(3, 0) != 0);
        step(w, 1'($urandom));
        if (accepted) begin
          acc++;
          if (!did && acc >= 20 && busy == 0 && cnt == RST_AT && cnt < FL_G) begin
            do_reset();
            did = 1'b1;
          end
        end
      end
      for (int c = 0; c < 20 && (q.size() != 0 || busy > 0); c++) begin
        step(1'b0, 1'b0);
      end
      @(negedge clk);
      #1 chk(g, "queue_drained", q.size(), 0);
      chk(g, "directed_count", int'(ncap >= NDS), 1);
      for (int i = 0; i < NDS; i++) begin
        chk(g, $sformatf("directed_sym%0d", i), int'(cap[i]), int'(DS[2*i +: 2]));
      end
      fin = 1'b1;
    end

    // Monitor: compare every presented symbol against the oldest prediction.
    initial begin
      forever begin
        @(negedge clk);
        if (!rst_g) begin
          last_sym = 2'b00;
          prev_done = 1'b0;
        end else if (valid_g) begin
          chk(g, "expected_available", int'(q.size() != 0), 1);
          if (q.size() != 0) begin
            em = q.pop_front();
            chk(g, "symbol", int'(enc_g), int'(em.sym));
            chk(g, "frame_start", int'(start_g), int'(em.st));
            chk(g, "frame_done", int'(done_g), int'(em.dn));
            chk(g, "word_ct", int'(wct_g), int'(em.wc));
            prev_done = em.dn;
          end
          if (ncap < 8) begin
            cap[ncap] = enc_g;
            ncap++;
          end
          last_sym = enc_g;
        end else begin
          chk(g, "hold_symbol", int'(enc_g), int'(last_sym));
          chk(g, "idle_start", int'(start_g), 0);
          chk(g, "idle_done", int'(done_g), 0);
          if (prev_done) chk(g, "wct_after_frame", int'(wct_g), 0);
          prev_done = 1'b0;
        end
      end
    end
  end

  // Wait for every configuration to finish, then summarise.
  initial begin
    bit all_fin;
    all_fin = 1'b0;
    for (int c = 0; c < 60000 && !all_fin; c++) begin
      @(negedge clk);
      all_fin = cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin;
    end
    chk(-1, "all_finished", int'(all_fin), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
